// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Reset sequencer and lock supervisor for a bank of PLL/MMCM instances.
// Each PLL has its own FSM (RESET -> WAIT_LOCK -> STABLE -> RUN, with FAULT
// after too many failed lock attempts). It drives the PLL RST pin and the
// BUFGCE enable of its outputs. All outputs come straight from flops.
module pll_lock_supervisor #(
    parameter int NUM_PLLS      = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SEQUENTIAL    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                restart_i,
    input  logic [NUM_PLLS-1:0] pll_lock_i,
    output logic [NUM_PLLS-1:0] pll_rst_o,
    output logic [NUM_PLLS-1:0] clk_en_o,
    output logic [NUM_PLLS-1:0] fault_o,
    output logic [NUM_PLLS-1:0] relock_o,
    output logic                all_ready_o
);

    localparam int MAX_TC_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_TC   = (LOCK_TIMEOUT > MAX_TC_A) ? LOCK_TIMEOUT : MAX_TC_A;
    localparam int CNT_W    = $clog2(MAX_TC) + 1;
    localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_TC     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_TC    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_ZERO = {RETRY_W{1'b0}};
    localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
    localparam logic               SEQ_EN     = (SEQUENTIAL != 32'sd0);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // A failed lock attempt either retries with a fresh reset pulse or,
    // when this was the last permitted attempt, parks the PLL in FAULT.
    function automatic state_t fail_state(input logic [RETRY_W-1:0] retry);
        if (retry == RETRY_LAST) begin
            return ST_FAULT;
        end else begin
            return ST_RESET;
        end
    endfunction

    logic [NUM_PLLS-1:0] sync1_q;
    logic [NUM_PLLS-1:0] lk_q;

    state_t              state_q [NUM_PLLS];
    state_t              state_d [NUM_PLLS];
    logic [CNT_W-1:0]    cnt_q   [NUM_PLLS];
    logic [CNT_W-1:0]    cnt_d   [NUM_PLLS];
    logic [RETRY_W-1:0]  retry_q [NUM_PLLS];
    logic [RETRY_W-1:0]  retry_d [NUM_PLLS];
    logic [NUM_PLLS-1:0] loss_d;
    logic                prev_run_d;
    logic                gate_d;

    logic [NUM_PLLS-1:0] pll_rst_q, pll_rst_d;
    logic [NUM_PLLS-1:0] clk_en_q,  clk_en_d;
    logic [NUM_PLLS-1:0] fault_q,   fault_d;
    logic [NUM_PLLS-1:0] relock_q,  relock_d;
    logic                all_ready_q, all_ready_d;

    // Two-flop synchroniser bringing the raw LOCKED pins into the clk domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= {NUM_PLLS{1'b0}};
            lk_q    <= {NUM_PLLS{1'b0}};
        end else begin
            sync1_q <= pll_lock_i;
            lk_q    <= sync1_q;
        end
    end

    // Per-PLL state, cycle counter and retry counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PLLS; i++) begin
                state_q[i] <= ST_RESET;
                cnt_q[i]   <= CNT_ZERO;
                retry_q[i] <= RETRY_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_PLLS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                retry_q[i] <= retry_d[i];
            end
        end
    end

    // Next-state logic; PLL i sees PLL i-1's next state so that ordered
    // enables rise and fall on the same edge along the chain.
    always_comb begin
        prev_run_d = 1'b1;
        gate_d     = 1'b1;
        loss_d     = {NUM_PLLS{1'b0}};
        for (int i = 0; i < NUM_PLLS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            retry_d[i] = retry_q[i];
        end
        for (int i = 0; i < NUM_PLLS; i++) begin
            gate_d = prev_run_d | ~SEQ_EN;
            if (restart_i) begin
                // restart overrides every event seen in the same cycle
                state_d[i] = ST_RESET;
                cnt_d[i]   = CNT_ZERO;
                retry_d[i] = RETRY_ZERO;
            end else begin
                case (state_q[i])
                    ST_RESET: begin
                        if (cnt_q[i] == RST_TC) begin
                            state_d[i] = ST_WAIT_LOCK;
                            cnt_d[i]   = CNT_ZERO;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lk_q[i]) begin
                            state_d[i] = ST_STABLE;
                            cnt_d[i]   = CNT_ZERO;
                        end else if (cnt_q[i] == LOCK_TC) begin
                            state_d[i] = fail_state(retry_q[i]);
                            cnt_d[i]   = CNT_ZERO;
                            retry_d[i] = retry_q[i] + RETRY_ONE;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_STABLE: begin
                        if (!lk_q[i]) begin
                            state_d[i] = fail_state(retry_q[i]);
                            cnt_d[i]   = CNT_ZERO;
                            retry_d[i] = retry_q[i] + RETRY_ONE;
                        end else if (cnt_q[i] == STABLE_TC) begin
                            if (gate_d) begin
                                state_d[i] = ST_RUN;
                                cnt_d[i]   = CNT_ZERO;
                                retry_d[i] = RETRY_ZERO;
                            end else begin
                                // hold saturated until the predecessor runs
                                cnt_d[i]   = STABLE_TC;
                            end
                        end else begin
                            cnt_d[i]   = cnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_RUN: begin
                        retry_d[i] = RETRY_ZERO;
                        if (!lk_q[i]) begin
                            // lock loss in RUN relocks without costing a retry
                            state_d[i] = ST_RESET;
                            cnt_d[i]   = CNT_ZERO;
                            loss_d[i]  = 1'b1;
                        end else if (!gate_d) begin
                            // predecessor dropped out: fall back without a reset
                            state_d[i] = ST_STABLE;
                            cnt_d[i]   = STABLE_TC;
                        end else begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    ST_FAULT: begin
                        state_d[i] = ST_FAULT;
                    end
                    default: begin
                        state_d[i] = ST_RESET;
                        cnt_d[i]   = CNT_ZERO;
                        retry_d[i] = RETRY_ZERO;
                    end
                endcase
            end
            prev_run_d = (state_d[i] == ST_RUN);
        end
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state register.
    always_comb begin
        pll_rst_d   = {NUM_PLLS{1'b0}};
        clk_en_d    = {NUM_PLLS{1'b0}};
        fault_d     = {NUM_PLLS{1'b0}};
        relock_d    = loss_d;
        all_ready_d = 1'b1;
        for (int i = 0; i < NUM_PLLS; i++) begin
            case (state_d[i])
                ST_RESET:     pll_rst_d[i] = 1'b1;
                ST_WAIT_LOCK: pll_rst_d[i] = 1'b0;
                ST_STABLE:    pll_rst_d[i] = 1'b0;
                ST_RUN:       clk_en_d[i]  = 1'b1;
                ST_FAULT: begin
                    pll_rst_d[i] = 1'b1;
                    fault_d[i]   = 1'b1;
                end
                default:      pll_rst_d[i] = 1'b1;
            endcase
            all_ready_d = all_ready_d & (state_q[i] == ST_RUN);
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pll_rst_q   <= {NUM_PLLS{1'b1}};
            clk_en_q    <= {NUM_PLLS{1'b0}};
            fault_q     <= {NUM_PLLS{1'b0}};
            relock_q    <= {NUM_PLLS{1'b0}};
            all_ready_q <= 1'b0;
        end else begin
            pll_rst_q   <= pll_rst_d;
            clk_en_q    <= clk_en_d;
            fault_q     <= fault_d;
            relock_q    <= relock_d;
            all_ready_q <= all_ready_d;
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign clk_en_o    = clk_en_q;
    assign fault_o     = fault_q;
    assign relock_o    = relock_q;
    assign all_ready_o = all_ready_q;

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised reset sequencer and lock supervisor for the board's clock-generation PLLs and MMCMs. Drives each PLL's RST pin and the CE of its BUFGCE output buffers. Replaces a bare "CE = LOCKED" gate with:
- a timed reset pulse;
- lock-timeout detection with bounded retries;
- stability qualification before clocks are released;
- optional ordered bring-up;
- automatic relock after lock loss.

It runs on the free-running reference clock, taken from the differential input buffer before any PLL.

## Interface
Parameters:
- NUM_PLLS, 2: number of supervised PLL/MMCM instances.
- RST_CYCLES, 16: width of the PLL reset pulse, in clk cycles. Must be at least 1.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024: consecutive locked cycles required before enabling clocks.
- MAX_RETRIES, 3: failed lock attempts allowed before FAULT.
- SEQUENTIAL, 1: when 1, PLL i may enter RUN only while PLL i-1 is in RUN.

Ports:
- clk, in, 1: free-running reference clock (125 MHz).
- rst, in, 1: reset, asynchronous, active-high.
- restart, in, 1: one-cycle pulse; re-runs the full sequence for all PLLs and clears faults.
- pll_lock, in, NUM_PLLS: raw LOCKED outputs. Asynchronous to clk.
- pll_rst, out, NUM_PLLS: PLL RST pins.
- clk_en, out, NUM_PLLS: BUFGCE CE for each PLL's outputs.
- fault, out, NUM_PLLS: PLL exhausted its retries.
- relock, out, NUM_PLLS: one-cycle pulse when a PLL in RUN loses lock.
- all_ready, out, 1: every PLL is in RUN.

## Operation
- Each pll_lock bit passes through a 2-FF synchroniser. Call the synchronised value lk[i].
- Per PLL there is an independent FSM with states RESET, WAIT_LOCK, STABLE, RUN, FAULT. Each FSM has a cycle counter and a retry counter.
- RESET: pll_rst=1, clk_en=0. After exactly RST_CYCLES cycles, go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: pll_rst=0.
  - If lk=1, go to STABLE next cycle.
  - If the counter reaches LOCK_TIMEOUT-1 with lk=0, increment retry. Go to FAULT if retry+1 == MAX_RETRIES, otherwise go to RESET.
- STABLE: the counter increments while lk=1.
  - If lk=0, go to RESET with retry incremented. The same FAULT rule as WAIT_LOCK applies.
  - When the counter reaches STABLE_CYCLES-1, go to RUN, subject to the SEQUENTIAL gate. While gated, stay in STABLE with the counter saturated.
- RUN: clk_en=1 and retry is cleared.
  - If lk=0, set clk_en=0, pulse relock for one cycle, and go to RESET. This is not counted as a retry.
  - If SEQUENTIAL=1 and PLL i-1 leaves RUN, PLL i returns to STABLE (counter saturated, no reset). Its clk_en drops in the same cycle as PLL i-1's clk_en.
- FAULT: pll_rst=1, clk_en=0, fault=1. Only restart or rst exits this state.
- all_ready = AND of (state==RUN) over all PLLs, registered.
- restart puts every FSM into RESET with counters and retries cleared. restart wins over every simultaneous event: lock loss, timeout, stability completion.
- Counter widths are $clog2 of the largest terminal count plus 1. Counters never wrap: they clear on every state entry and saturate in STABLE.

## Timing
- Reset values:
  - pll_rst = all 1;
  - clk_en, fault, relock = 0;
  - all_ready = 0;
  - all FSMs in RESET with counters at 0;
  - synchroniser flops at 0.
- After rst deasserts, pll_rst[i] stays high for RST_CYCLES rising edges and falls on edge RST_CYCLES.
- Lock input latency: a pll_lock change sampled at edge k is visible as lk at edge k+1. The FSM reacts at edge k+2.
- With pll_lock constantly high, clk_en[0] rises STABLE_CYCLES+1 edges after pll_rst[0] falls.
- Lock loss in RUN: pll_lock falls before edge k. clk_en and relock change at edge k+2, and pll_rst rises at that same edge.
- All outputs are driven directly from registers, with no combinational path from input to output.
- rst asserted mid-sequence returns every output to its reset value immediately (asynchronously).
- Successive retries are separated by a full RST_CYCLES reset pulse.

## Test plan
Common configuration: NUM_PLLS=2, RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SEQUENTIAL=1.
- Clean bring-up, pll_lock=2'b11 from t=0:
  - pll_rst falls on edge 4;
  - clk_en[0] and clk_en[1] rise on edge 13;
  - all_ready rises on edge 14.
- Timeout, pll_lock[0] held 0:
  - pll_rst[0] pulses for 4 cycles twice, separated by 20-cycle waits;
  - fault[0]=1 at edge 48 and stays high;
  - clk_en stays 2'b00.
- Glitch in STABLE: pll_lock[0] drops for 1 cycle mid-count, then rises 3 cycles later:
  - PLL 0 re-enters RESET, retry=1;
  - bring-up completes on the second attempt;
  - fault stays 0.
- Ordering: lock[1] is high from t=0 and lock[0] rises at t=30. clk_en[1] must not rise before clk_en[0]; both rise on the same edge.
- Lock loss in RUN: lock[0] falls.
  - relock[0] pulses once;
  - clk_en[0] and clk_en[1] fall 2 edges after the sample;
  - PLL 1 holds in STABLE with pll_rst[1]=0 and resumes when PLL 0 returns to RUN.
- Restart during FAULT together with a simultaneous lock loss: fault clears, both FSMs go to RESET, and pll_rst is high for 4 cycles.
